// File: rtl/psg_pkg.sv
// Shared types and constants for the PSG voice sequencer and waveform generator.
package psg_pkg;

  localparam int unsigned NUM_VOICES = 16;

  typedef enum logic [1:0] {WF_PULSE, WF_SAW, WF_TRI, WF_NOISE} wf_e;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_CALC, ST_DONE} state_e;

  // Attribute word field positions
  localparam int unsigned FREQ_LSB  = 0;
  localparam int unsigned FREQ_MSB  = 15;
  localparam int unsigned PW_LSB    = 16;
  localparam int unsigned PW_MSB    = 21;
  localparam int unsigned WF_LSB    = 22;
  localparam int unsigned WF_MSB    = 23;
  localparam int unsigned VOL_LSB   = 24;
  localparam int unsigned VOL_MSB   = 29;
  localparam int unsigned LEFT_BIT  = 30;
  localparam int unsigned RIGHT_BIT = 31;

  localparam int unsigned LFSR_TAP_A = 15;
  localparam int unsigned LFSR_TAP_B = 13;
  localparam int unsigned LFSR_TAP_C = 12;
  localparam int unsigned LFSR_TAP_D = 10;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
  endfunction

endpackage

// File: rtl/psg_waveform.sv
// Combinational waveform generator: top phase bits, pulse width, shape and noise
// bits in, signed 6-bit sample out.
module psg_waveform
  import psg_pkg::*;
(
  input  logic [6:0]        phase_hi,
  input  logic [5:0]        pw,
  input  wf_e               wf,
  input  logic [5:0]        noise,
  output logic signed [5:0] w
);

  logic [5:0] p;
  logic [5:0] tri_mag;

  assign p       = phase_hi[6:1];
  assign tri_mag = phase_hi[6] ? ~phase_hi[5:0] : phase_hi[5:0];

  always_comb begin
    w = '0;
    unique case (wf)
      WF_PULSE: w = (p < pw) ? 6'sd31 : -6'sd32;
      WF_SAW:   w = p ^ 6'h20;
      WF_TRI:   w = tri_mag ^ 6'h20;
      WF_NOISE: w = noise;
    endcase
  end

endmodule

// File: rtl/psg_voice_sequencer.sv
// Walks all PSG voices once per sample tick, accumulating stereo output.
// Optional macro PSG_PHASE_RESET_EN: freq==0 forces the voice phase to 0.
module psg_voice_sequencer
  import psg_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 16,
  parameter int unsigned ACC_W      = 16,
  parameter logic [15:0] LFSR_SEED  = 16'h0001
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    sample_req_i,
  output logic                    rd_en_o,
  output logic [3:0]              rd_addr_o,
  input  logic [31:0]             rd_data_i,
  output logic                    busy_o,
  output logic                    sample_valid_o,
  output logic signed [ACC_W-1:0] left_o,
  output logic signed [ACC_W-1:0] right_o
);

  localparam logic [3:0] LAST_VOICE = 4'(NUM_VOICES - 1);

  state_e                  state, state_nx;
  logic [3:0]              v;
  logic [16:0]             phase [NUM_VOICES];
  logic signed [ACC_W-1:0] acc_l, acc_r;
  logic [15:0]             lfsr;

  logic [15:0]             freq;
  logic [5:0]              pw, vol;
  wf_e                     wf;
  logic [16:0]             cur_phase, phase_nx;
  logic signed [5:0]       w;
  logic signed [12:0]      prod;
  logic signed [ACC_W-1:0] contrib, acc_l_nx, acc_r_nx;

  assign freq      = rd_data_i[FREQ_MSB:FREQ_LSB];
  assign pw        = rd_data_i[PW_MSB:PW_LSB];
  assign vol       = rd_data_i[VOL_MSB:VOL_LSB];
  assign wf        = wf_e'(rd_data_i[WF_MSB:WF_LSB]);
  assign cur_phase = phase[v];

  psg_waveform u_wave (
    .phase_hi (cur_phase[16:10]),
    .pw       (pw),
    .wf       (wf),
    .noise    (lfsr[5:0]),
    .w        (w)
  );

  assign prod     = w * $signed({1'b0, vol});
  assign contrib  = ACC_W'(prod);
  assign acc_l_nx = rd_data_i[LEFT_BIT]  ? acc_l + contrib : acc_l;
  assign acc_r_nx = rd_data_i[RIGHT_BIT] ? acc_r + contrib : acc_r;

`ifdef PSG_PHASE_RESET_EN
  assign phase_nx = (freq == '0) ? '0 : cur_phase + {1'b0, freq};
`else
  assign phase_nx = cur_phase + {1'b0, freq};
`endif

  always_comb begin
    state_nx       = state;
    rd_en_o        = 1'b0;
    rd_addr_o      = '0;
    busy_o         = (state != ST_IDLE);
    sample_valid_o = 1'b0;
    unique case (state)
      ST_IDLE:  if (sample_req_i) state_nx = ST_FETCH;
      ST_FETCH: begin
        rd_en_o   = 1'b1;
        rd_addr_o = v;
        state_nx  = ST_CALC;
      end
      ST_CALC:  state_nx = (v == LAST_VOICE) ? ST_DONE : ST_FETCH;
      ST_DONE: begin
        sample_valid_o = 1'b1;
        state_nx       = ST_IDLE;
      end
    endcase
  end

  // Outputs are loaded with the final sums as CALC(15) retires, so they are
  // already stable during the DONE cycle that carries the valid strobe.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= ST_IDLE;
      v       <= '0;
      acc_l   <= '0;
      acc_r   <= '0;
      left_o  <= '0;
      right_o <= '0;
      lfsr    <= LFSR_SEED;
      for (int unsigned i = 0; i < NUM_VOICES; i++) phase[i] <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        ST_IDLE: if (sample_req_i) begin
          acc_l <= '0;
          acc_r <= '0;
          v     <= '0;
        end
        ST_CALC: begin
          phase[v] <= phase_nx;
          lfsr     <= lfsr_next(lfsr);
          acc_l    <= acc_l_nx;
          acc_r    <= acc_r_nx;
          if (v == LAST_VOICE) begin
            left_o  <= acc_l_nx;
            right_o <= acc_r_nx;
          end else begin
            v <= v + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
